// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per accepted handshake, forward order.
// Define AES_KEY_EXPAND_REVERSE_EN to pre-compute all keys into a buffer and emit them 10..0.
module aes_key_expand #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_idx,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy
);

    if (NR != 10) begin : g_bad_nr
        $error("aes_key_expand supports only NR=10");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        sbox = SBOX_TABLE[{(8'd255 - b), 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    state_t       state_r;
    logic [7:0]   rcon_r;
    logic [31:0]  rot_s;
    logic [31:0]  t_s;
    logic [31:0]  n0_s;
    logic [31:0]  n1_s;
    logic [31:0]  n2_s;
    logic [31:0]  n3_s;
    logic [127:0] next_key_s;

`ifdef AES_KEY_EXPAND_REVERSE_EN
    logic [127:0] key_buf_r [0:10];
`endif

    // Next round key from the current rk_out and rcon.
    always_comb begin
        rot_s      = {rk_out[23:0], rk_out[31:24]};
        t_s        = {sbox(rot_s[31:24]), sbox(rot_s[23:16]), sbox(rot_s[15:8]), sbox(rot_s[7:0])}
                     ^ {rcon_r, 24'h000000};
        n0_s       = rk_out[127:96] ^ t_s;
        n1_s       = rk_out[95:64] ^ n0_s;
        n2_s       = rk_out[63:32] ^ n1_s;
        n3_s       = rk_out[31:0] ^ n2_s;
        next_key_s = {n0_s, n1_s, n2_s, n3_s};
    end

`ifdef AES_KEY_EXPAND_REVERSE_EN
    // Key buffer fill during GEN; rk_idx doubles as the write pointer.
    always_ff @(posedge clk) begin
        if (state_r == ST_GEN) begin
            key_buf_r[rk_idx] <= rk_out;
        end
    end
`endif

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            key_ready <= 1'b1;
            rk_valid  <= 1'b0;
            rk_out    <= 128'h0;
            rk_idx    <= 4'd0;
            busy      <= 1'b0;
            rcon_r    <= 8'h01;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (key_valid && key_ready) begin
                        rk_out    <= key_in;
                        rk_idx    <= 4'd0;
                        rcon_r    <= 8'h01;
                        key_ready <= 1'b0;
                        busy      <= 1'b1;
`ifdef AES_KEY_EXPAND_REVERSE_EN
                        state_r   <= ST_GEN;
`else
                        rk_valid  <= 1'b1;
                        state_r   <= ST_EMIT;
`endif
                    end
                end
`ifdef AES_KEY_EXPAND_REVERSE_EN
                ST_GEN: begin
                    // rk_out already holds key 10 on the last GEN cycle, so it is presented as-is.
                    if (rk_idx == 4'd10) begin
                        rk_valid <= 1'b1;
                        state_r  <= ST_EMIT;
                    end else begin
                        rk_out <= next_key_s;
                        rk_idx <= rk_idx + 4'd1;
                        rcon_r <= xtime(rcon_r);
                    end
                end
                ST_EMIT: begin
                    if (rk_valid && rk_ready) begin
                        if (rk_idx == 4'd0) begin
                            rk_valid  <= 1'b0;
                            key_ready <= 1'b1;
                            busy      <= 1'b0;
                            state_r   <= ST_IDLE;
                        end else begin
                            rk_out <= key_buf_r[rk_idx - 4'd1];
                            rk_idx <= rk_idx - 4'd1;
                        end
                    end
                end
`else
                ST_EMIT: begin
                    if (rk_valid && rk_ready) begin
                        if (rk_idx == 4'd10) begin
                            rk_valid  <= 1'b0;
                            key_ready <= 1'b1;
                            busy      <= 1'b0;
                            state_r   <= ST_IDLE;
                        end else begin
                            rk_out <= next_key_s;
                            rk_idx <= rk_idx + 4'd1;
                            rcon_r <= xtime(rcon_r);
                        end
                    end
                end
`endif
                default: begin
                    state_r   <= ST_IDLE;
                    key_ready <= 1'b1;
                    rk_valid  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Iterative AES-128 key schedule. Sits directly upstream of the round datapath.
- Accepts one 128-bit cipher key and emits the 11 round keys (index 0..10), one per accepted handshake.
- Each round key is emitted as a flat 128-bit word, ready for the add-round-key step of each round.
- One new round key per cycle when the consumer is always ready; no bubbles between keys.

Parameters:
- NR, 10, number of rounds; emitted keys are 0..NR. Only 10 is supported; any other value is a compile-time error.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- key_in  input  128  cipher key; byte 0 in [127:120], FIPS-197 column-major (word w0 = [127:96]).
- key_valid  input  1  key_in is valid.
- key_ready  output  1  block can accept a new key.
- rk_out  output  128  current round key, same byte order as key_in.
- rk_idx  output  4  round index of rk_out, 0..10.
- rk_valid  output  1  rk_out/rk_idx are valid.
- rk_ready  input  1  consumer accepts rk_out this cycle.
- busy  output  1  high whenever a key is in flight (state != IDLE).

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; key_ready=1; rk_valid=0; rk_out=0; rk_idx=0; busy=0; rcon register=8'h01.
- All outputs are registered.
- Handshakes:
  - Key accept = key_valid & key_ready.
  - Key transfer = rk_valid & rk_ready.
  - While rk_valid=1 and rk_ready=0, rk_out and rk_idx hold stable.
  - rk_valid never drops without a transfer, except on reset.
- IDLE:
  - key_ready=1.
  - On accept: rk_out<=key_in, rk_idx<=0, rk_valid<=1, rcon<=8'h01, key_ready<=0, next state EMIT.
  - Latency is 1 cycle from accept to rk_valid.
- EMIT:
  - On transfer with rk_idx<10:
    - rk_out <= next_key(rk_out, rcon); rk_idx <= rk_idx+1; rk_valid stays 1.
    - rcon <= xtime(rcon), i.e. {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 0).
    - The rcon sequence is 01,02,04,08,10,20,40,80,1b,36.
  - On transfer with rk_idx==10: rk_valid<=0, key_ready<=1, next state IDLE.
  - No transfer: hold.
- next_key, with words w0..w3 of the current key:
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}. RotWord is a left byte-rotate; SubWord applies the AES S-box to each byte.
  - n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2.
- S-box: internal 256-entry constant table. 4 instances, combinational, in the key-update path.
- key_valid while busy: ignored (key_ready=0), and key_in is not sampled.
  - The earliest next accept is the cycle after the idx-10 transfer.
  - The ready-to-accept turnaround is exactly 1 idle cycle.
- rst asserted mid-sequence: everything returns to reset values immediately; the partial sequence is abandoned and no further keys are emitted.
- rk_ready high while rk_valid=0: no effect.

Optional Feature:
- Macro: AES_KEY_EXPAND_REVERSE_EN.
- Defined (decryption ordering):
  - Adds an internal 11x128 key buffer and a GEN state between IDLE and EMIT.
  - GEN: after accept, compute keys 0..10 one per cycle into the buffer, with rk_valid=0 and busy=1. GEN lasts 11 cycles.
  - EMIT then presents buffer[10] first with rk_idx=10, and decrements on each transfer down to rk_idx=0.
  - The idx-0 transfer returns to IDLE.
  - Latency from accept to first rk_valid is 12 cycles.
  - Reset clears state and control only. Buffer contents are don't-care after reset.
- Undefined: forward order only. No buffer is inferred; behaviour is as above.

Test Plan:
- Reset, then accept key 2b7e151628aed2a6abf7158809cf4f3c with rk_ready=1 constantly.
  - Expect rk_idx 0..10 on 11 consecutive cycles.
  - idx0=2b7e1516...cf4f3c; idx1=a0fafe1788542cb123a339392a6c7605; idx2=f2c295f27a96b9435935807a7359f67f; idx10=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - key_ready returns high the cycle after idx10.
- Same key, random rk_ready stalls.
  - rk_out and rk_idx stay stable across every stalled cycle.
  - The sequence is identical to the first scenario, with no skipped or duplicated index.
- key_valid held high with a different key during emission.
  - Ignored until IDLE; the second key's idx0 appears 1 cycle after the second accept.
- Key 00000000000000000000000000000000.
  - idx1=62636363626363636263636362636363; idx10=b4ef5bcb3e92e21123e951cf6f8f188e.
- Assert rst at rk_idx=5.
  - rk_valid=0 and key_ready=1 immediately, without waiting for a clock edge.
  - A new key afterwards produces a correct sequence from idx0 with rcon restarted at 01.
- With AES_KEY_EXPAND_REVERSE_EN and the FIPS key:
  - First rk_valid arrives 12 cycles after accept, with rk_idx=10 and rk_out=d014f9a8...630ca6.
  - The last key has idx0 = key_in.
